// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type, flag bit indices and the per-opcode
// flag write mask for alu_arbiter.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_XOR = 4'h3;
    localparam logic [3:0] OP_SLL = 4'h4;
    localparam logic [3:0] OP_SRA = 4'h5;
    localparam logic [3:0] OP_ROR = 4'h6;
    localparam logic [3:0] OP_OR  = 4'h7;
    localparam logic [3:0] OP_NOT = 4'h8;
    localparam logic [3:0] OP_MOV = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int FLAG_N = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } arb_state_e;

    // {N,V,Z} bits an opcode is allowed to produce and to write back.
    function automatic logic [2:0] flag_mask(input logic [3:0] op);
        logic [2:0] mask;
        mask = '0;
        case (op)
            OP_ADD, OP_SUB:                 mask = 3'b111;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: mask = 3'b001;
            default:                        mask = 3'b000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/alu_arbiter_arb2.sv
// Two-input grant logic: fixed priority (port 0 wins) by default,
// round-robin with a last-granted pointer when ALU_ARB_RR_EN is defined.
module arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

`ifdef ALU_ARB_RR_EN
    logic last_q;

    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = last_q ? 2'b01 : 2'b10;
        end
    end

    // Reset value means "port 1 granted last", so port 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (advance && (valid != 2'b00)) begin
            last_q <= grant[1];
        end
    end
`else
    logic unused_ports;

    always_comb begin
        grant = '0;
        if (valid[0]) begin
            grant = 2'b01;
        end else if (valid[1]) begin
            grant = 2'b10;
        end
    end

    assign unused_ports = ^{clk, rst_n, advance};
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between port 0 (execute) and port 1 (debug).
// Arbitration mode selected by ALU_ARB_RR_EN (round-robin) vs fixed priority.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DW  = 16,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst_n,

    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [OPW-1:0] req0_op,
    input  logic [DW-1:0]  req0_a,
    input  logic [DW-1:0]  req0_b,
    output logic           resp0_valid,
    input  logic           resp0_ready,

    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [OPW-1:0] req1_op,
    input  logic [DW-1:0]  req1_a,
    input  logic [DW-1:0]  req1_b,
    output logic           resp1_valid,
    input  logic           resp1_ready,

    output logic [DW-1:0]  resp_data,
    output logic [2:0]     resp_flags,

    output logic [OPW-1:0] alu_op,
    output logic [DW-1:0]  alu_in1,
    output logic [DW-1:0]  alu_in2,
    input  logic [DW-1:0]  alu_out,
    input  logic [2:0]     alu_flags,

    output logic [2:0]     flags_q
);

    arb_state_e     state, state_next;
    logic [OPW-1:0] op_q;
    logic [DW-1:0]  a_q;
    logic [DW-1:0]  b_q;
    logic           grant_q;
    logic [1:0]     grant;
    logic           accept;
    logic           in_idle;
    logic [2:0]     mask;
    logic [2:0]     flags_calc;
    logic           alu_z_unused;

    assign in_idle = (state == ST_IDLE);

    arb2 u_arb2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid   ({req1_valid, req0_valid}),
        .advance (in_idle),
        .grant   (grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        resp0_valid = 1'b0;
        resp1_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req0_valid || req1_valid) begin
                    accept     = 1'b1;
                    req0_ready = grant[0];
                    req1_ready = grant[1];
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_next = ST_RESP;
            end
            ST_RESP: begin
                resp0_valid = ~grant_q;
                resp1_valid = grant_q;
                if (grant_q ? resp1_ready : resp0_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign alu_op  = op_q;
    assign alu_in1 = a_q;
    assign alu_in2 = b_q;

    // Z is derived from alu_out here; the ALU's own Z bit is not used.
    assign alu_z_unused = alu_flags[FLAG_Z];
    assign mask         = flag_mask(op_q);
    assign flags_calc   = mask & {alu_flags[FLAG_N], alu_flags[FLAG_V], (alu_out == '0)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            grant_q    <= 1'b0;
            resp_data  <= '0;
            resp_flags <= '0;
            flags_q    <= '0;
        end else begin
            if (accept) begin
                grant_q <= grant[1];
                op_q    <= grant[1] ? req1_op : req0_op;
                a_q     <= grant[1] ? req1_a  : req0_a;
                b_q     <= grant[1] ? req1_b  : req0_b;
            end
            if (state == ST_EXEC) begin
                resp_data  <= alu_out;
                resp_flags <= flags_calc;
                if (!grant_q) begin
                    flags_q <= (flags_q & ~mask) | (flags_calc & mask);
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: transaction-level reference model
// checked every cycle, plus directed operations with literal expectations.
module tb_alu_arbiter;

    localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, AND = 4'h2, XOR = 4'h3,
                           SLL = 4'h4, SRA = 4'h5, ROR = 4'h6, ORR = 4'h7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_op = '0, req1_op = '0;
    logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        resp0_valid, resp1_valid;
    logic        resp0_ready = 1'b0, resp1_ready = 1'b0;
    logic [15:0] resp_data;
    logic [2:0]  resp_flags;
    logic [3:0]  alu_op;
    logic [15:0] alu_in1, alu_in2, alu_out;
    logic [2:0]  alu_flags;
    logic [2:0]  flags_q;

    int n_run = 0;
    int n_fail = 0;

    alu_arbiter #(.DW(16), .OPW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp_data(resp_data), .resp_flags(resp_flags),
        .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_out(alu_out), .alu_flags(alu_flags),
        .flags_q(flags_q)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_res(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        case (op)
            ADD: r = a + b;
            SUB: r = a - b;
            AND: r = a & b;
            XOR: r = a ^ b;
            SLL: r = a << b[3:0];
            SRA: r = $signed(a) >>> b[3:0];
            ROR: r = (a >> b[3:0]) | (a << (5'd16 - {1'b0, b[3:0]}));
            ORR: r = a | b;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [1:0] alu_nv(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        logic v;
        r = alu_res(op, a, b);
        v = 1'b0;
        if (op == ADD) v = (a[15] == b[15]) && (r[15] != a[15]);
        if (op == SUB) v = (a[15] != b[15]) && (r[15] != a[15]);
        return {r[15], v};
    endfunction

    // External ALU the arbiter drives.
    always_comb begin
        alu_out   = alu_res(alu_op, alu_in1, alu_in2);
        alu_flags = {alu_nv(alu_op, alu_in1, alu_in2), (alu_out == 16'h0)};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_phase = 0;  // 0 waiting for grant, 1 operation in ALU, 2 response offered
    int          m_port = 0;
    int          m_last = 1;
    logic [3:0]  m_op = '0;
    logic [15:0] m_a = '0, m_b = '0, m_data = '0;
    logic [2:0]  m_rf = '0, m_fq = '0;

    function automatic int pick(input logic v0, input logic v1, input int last);
`ifdef ALU_ARB_RR_EN
        if (v0 && v1) return (last == 0) ? 1 : 0;
`endif
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    always @(negedge clk) begin
        int g;
        logic [15:0] r;
        logic [1:0] nv;
        if (!rst_n) begin
            check("m_rst_ready", {req1_ready, req0_ready}, 0);
            check("m_rst_valid", {resp1_valid, resp0_valid}, 0);
            check("m_rst_data", resp_data, 0);
            check("m_rst_flags", {resp_flags, flags_q}, 0);
            check("m_rst_alu", {alu_op, alu_in1, alu_in2}, 0);
            m_phase = 0; m_last = 1; m_op = '0; m_a = '0; m_b = '0;
            m_data = '0; m_rf = '0; m_fq = '0;
        end else begin
            g = (m_phase == 0) ? pick(req0_valid, req1_valid, m_last) : -1;
            check("m_req0_ready", req0_ready, (g == 0));
            check("m_req1_ready", req1_ready, (g == 1));
            check("m_resp0_valid", resp0_valid, (m_phase == 2 && m_port == 0));
            check("m_resp1_valid", resp1_valid, (m_phase == 2 && m_port == 1));
            check("m_resp_data", resp_data, m_data);
            check("m_resp_flags", resp_flags, m_rf);
            check("m_flags_q", flags_q, m_fq);
            check("m_alu_ops", {alu_op, alu_in1, alu_in2}, {m_op, m_a, m_b});
            if (m_phase == 0 && g >= 0) begin
                m_port = g; m_last = g;
                m_op = (g == 0) ? req0_op : req1_op;
                m_a  = (g == 0) ? req0_a  : req1_a;
                m_b  = (g == 0) ? req0_b  : req1_b;
                m_phase = 1;
            end else if (m_phase == 1) begin
                r  = alu_res(m_op, m_a, m_b);
                nv = alu_nv(m_op, m_a, m_b);
                m_data = r;
                case (m_op)
                    ADD, SUB:           m_rf = {nv, (r == 16'h0)};
                    XOR, SLL, SRA, ROR: m_rf = {2'b00, (r == 16'h0)};
                    default:            m_rf = 3'b000;
                endcase
                if (m_port == 0) begin
                    if (m_op == ADD || m_op == SUB) m_fq = m_rf;
                    else if (m_op == XOR || m_op == SLL || m_op == SRA || m_op == ROR) m_fq[0] = m_rf[0];
                end
                m_phase = 2;
            end else if (m_phase == 2) begin
                if ((m_port == 0) ? resp0_ready : resp1_ready) m_phase = 0;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input int p, input logic v, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        if (p == 0) begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    // Called just after a rising edge with the DUT idle.
    task automatic run_op(input int p, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input int hold, input bit raise_other,
                          output logic [15:0] d, output logic [2:0] f);
        logic got;
        got = 1'b0;
        drive(p, 1'b1, op, a, b);
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = (p == 0) ? req0_ready : req1_ready;
        end
        check("accept", got, 1);
        @(posedge clk); #1;
        drive(p, 1'b0, op, a, b);
        if (raise_other) drive(1 - p, 1'b1, ADD, 16'd3, 16'd4);
        @(posedge clk); #1;
        check("resp_latency", (p == 0) ? resp0_valid : resp1_valid, 1);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("resp_hold_valid", (p == 0) ? resp0_valid : resp1_valid, 1);
            check("resp_hold_no_ready", {req1_ready, req0_ready}, 0);
        end
        d = resp_data;
        f = resp_flags;
        if (p == 0) resp0_ready = 1'b1; else resp1_ready = 1'b1;
        @(posedge clk); #1;
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        check("resp_done", (p == 0) ? resp0_valid : resp1_valid, 0);
    endtask

    initial begin
        logic [15:0] d;
        logic [2:0]  f;
        int grants[$];
        bit done;

        repeat (2) @(posedge clk);
        #1;
        check("rst_resp_data", resp_data, 16'h0);
        check("rst_flags_q", flags_q, 3'b000);
        check("rst_alu_op", alu_op, 4'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(0, ADD, 16'h7FFF, 16'h0001, 0, 0, d, f);
        check("add_ovf_data", d, 16'h8000);
        check("add_ovf_flags", f, 3'b110);
        check("add_ovf_flags_q", flags_q, 3'b110);

        run_op(0, XOR, 16'h00F0, 16'h00F0, 0, 0, d, f);
        check("xor_data", d, 16'h0000);
        check("xor_flags", f, 3'b001);
        check("xor_flags_q", flags_q, 3'b111);

        run_op(0, SUB, 16'h1234, 16'h1234, 0, 0, d, f);
        check("sub_zero_data", d, 16'h0000);
        check("sub_zero_flags_q", flags_q, 3'b001);

        run_op(1, ADD, 16'hFFFF, 16'h0001, 0, 0, d, f);
        check("p1_add_data", d, 16'h0000);
        check("p1_add_flags", f, 3'b001);
        check("p1_flags_q_kept", flags_q, 3'b001);

        // Both ports requesting continuously.
        drive(0, 1'b1, ADD, 16'd1, 16'd1);
        drive(1, 1'b1, ADD, 16'd2, 16'd2);
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (req0_ready) grants.push_back(0);
            if (req1_ready) grants.push_back(1);
            done = (grants.size() >= 4);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        check("tie_grant_count", grants.size(), 4);
        for (int i = 0; i < 4 && i < grants.size(); i++) begin
`ifdef ALU_ARB_RR_EN
            check("tie_grant_rr", grants[i], i % 2);
`else
            check("tie_grant_fixed", grants[i], 0);
`endif
        end

        // Stalled response, port 1 arriving while port 0 waits.
        run_op(0, SUB, 16'd3, 16'd5, 5, 1, d, f);
        check("hold_data", d, 16'hFFFE);
        check("hold_flags", f, 3'b100);
        check("hold_flags_q", flags_q, 3'b100);
        run_op(1, ADD, 16'd3, 16'd4, 0, 0, d, f);
        check("late_p1_data", d, 16'd7);
        check("late_p1_flags_q", flags_q, 3'b100);

        run_op(0, 4'hE, 16'h1111, 16'h2222, 0, 0, d, f);
        check("undef_op_data", d, 16'h0000);
        check("undef_op_flags", f, 3'b000);
        check("undef_op_flags_q", flags_q, 3'b100);

        // Reset while the operation is in the ALU.
        drive(0, 1'b1, ADD, 16'd1, 16'd2);
        done = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            done = req0_ready;
        end
        check("rst_accept", done, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_flags_q", flags_q, 3'b000);
        check("async_resp_data", resp_data, 16'h0);
        check("async_resp_valid", {resp1_valid, resp0_valid}, 0);
        check("async_alu", {alu_op, alu_in1}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("no_resp_after_rst", resp0_valid, 0);

        run_op(0, SUB, 16'h0000, 16'h0001, 0, 0, d, f);
        check("post_rst_data", d, 16'hFFFF);
        check("post_rst_flags", f, 3'b100);
        check("post_rst_flags_q", flags_q, 3'b100);

        @(posedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational ALU between two requesters: port 0 (core execute stage) and port 1 (debug/self-test port). It grants one operation at a time, drives the ALU from registered operands, captures the result and computed flags, and returns them on a per-port response handshake. It also owns the architectural N/V/Z flag register, which only port 0 operations update.

## Interface
Parameters:
- DW, 16, operand/result width
- OPW, 4, opcode width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- reqN_valid  in  1  port N (N=0,1) has an operation
- reqN_ready  out  1  one-cycle accept pulse for port N
- reqN_op  in  OPW  opcode for port N
- reqN_a, reqN_b  in  DW  operands for port N
- respN_valid  out  1  result for port N is available
- respN_ready  in  1  port N consumes the result
- resp_data  out  DW  result, shared by both ports
- resp_flags  out  3  {N,V,Z} computed for this operation
- alu_op  out  OPW  to ALU opcode
- alu_in1, alu_in2  out  DW  to ALU operands
- alu_out  in  DW  from ALU result
- alu_flags  in  3  from ALU {N,V,Z}
- flags_q  out  3  architectural flag register {N,V,Z}

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any reqN_valid, grant one port and assert its reqN_ready for that cycle only.
  - Capture op, a and b into operand registers, record the grant, and go to EXEC.
  - With no request, stay in IDLE.
- EXEC:
  - alu_op, alu_in1 and alu_in2 always come from the operand registers.
  - Capture alu_out into resp_data.
  - Compute resp_flags:
    - Z = (alu_out == 0) for ADD(0000), SUB(0001), XOR(0011), SLL(0100), SRA(0101), ROR(0110); otherwise 0.
    - N and V = alu_flags[2] and alu_flags[1] for ADD and SUB only; otherwise 0.
  - If the grant was port 0, write flags_q:
    - ADD/SUB write N, V and Z.
    - XOR/SLL/SRA/ROR write Z only.
    - All other opcodes leave flags_q unchanged.
  - Go to RESP.
- RESP:
  - Assert respN_valid for the granted port only.
  - Hold resp_data and resp_flags stable until respN_ready is sampled high, then go to IDLE.
  - The other port's respN_ready is ignored.
- Any opcode is accepted. Opcodes the ALU does not define produce whatever alu_out gives (0), with Z=1 computed only for the listed ops.
- Port 1 never modifies flags_q.

## Timing
- Reset values:
  - state=IDLE
  - reqN_ready=0, respN_valid=0
  - resp_data=0, resp_flags=0, flags_q=0
  - operand registers=0, so alu_op/alu_in1/alu_in2=0
  - arbitration pointer = "last granted port 1"
- Accept at edge T (reqN_ready high in cycle T-1→T).
  - resp_data and flags_q update at edge T+1.
  - respN_valid is high from T+1.
- Minimum period is 3 cycles per operation: IDLE, EXEC, RESP each last at least one cycle, and RESP lasts until ready.
- reqN_ready is combinational from reqN_valid in IDLE only. It is never asserted outside IDLE.
- Both valid in the same cycle: the arbitration rule picks exactly one. The loser keeps valid and is served next IDLE.
- Requester must hold valid/op/a/b stable until ready; the block samples only on the accept edge.
- Reset asserted mid-operation: in-flight operation discarded with no response; flags_q returns to 0 immediately (asynchronous).

## Configuration
- ALU_ARB_RR_EN defined: round-robin arbitration.
  - On a tie, grant the port not granted last.
  - The pointer updates on every grant.
- ALU_ARB_RR_EN undefined: fixed priority.
  - Port 0 always wins ties.
  - No pointer register exists.

## Structure
- Shared package alu_pkg:
  - opcode localparams (ADD through HLT, 4-bit)
  - FSM state typedef
  - flag bit indices FLAG_N=2, FLAG_V=1, FLAG_Z=0
  - flag write-mask function by opcode
- One natural sub-module, arb2: 2-input grant logic with the optional round-robin pointer, isolating the macro-controlled logic.

## Test plan
- Port 0 ADD a=0x7FFF b=0x0001 → resp0_valid two edges after accept, resp_data=0x8000, resp_flags=3'b110, flags_q=3'b110.
- Port 0 SUB a=0x1234 b=0x1234, then port 1 ADD 0xFFFF+0x0001 → port 0 result 0x0000, flags_q=3'b001; port 1 response 0x0000, flags_q remains 3'b001.
- Port 0 XOR 0x00F0^0x00F0 after flags_q=3'b110 → resp_data=0, flags_q=3'b111 (N, V kept).
- Both ports valid continuously (ADD 1+1 and 2+2) → with ALU_ARB_RR_EN grants alternate 0,1,0,1; without it port 0 is granted every time and port 1 starves.
- Hold resp0_ready=0 for 5 cycles → resp0_valid and resp_data stable; no reqN_ready pulses; response completes on the first ready cycle.
- Assert rst_n=0 during EXEC → all outputs go to reset values without waiting for clk; no response issued; the next request after reset completes normally.
